rob_alloc: RTL and testbench

Dispatch-side allocator for the reorder buffer, one stage upstream of the ROB. Each cycle it grants up to two ROB entries to the dispatch stage, producing the per-slot dispatch valids and ROB addresses the ROB consumes (`dp1`/`dp1_addr`, `dp2`/`dp2_addr`). It tracks occupancy from retire counts so dispatch stalls exactly when the ROB is full. On a pipeline flush it realigns its tail to the commit pointer.

---
 rtl/rob_alloc.sv | 91 +++++++++
 tb/tb_rob_alloc.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/rob_alloc.sv
// Dispatch-side ROB allocator: grants up to two ROB entries per cycle, tracks
// occupancy from retire counts and realigns the tail to the head on flush.
module rob_alloc #(
  parameter int ROB_NUM = 64,
  parameter int ROB_SEL = 6
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [1:0]         req_num_i,
  input  logic               stall_i,
  input  logic               flush_i,
  input  logic [1:0]         commit_num_i,
  output logic               alloc_ok_o,
  output logic               dp1_o,
  output logic [ROB_SEL-1:0] dp1_addr_o,
  output logic               dp2_o,
  output logic [ROB_SEL-1:0] dp2_addr_o,
  output logic [ROB_SEL-1:0] dispatch_ptr_o,
  output logic [ROB_SEL-1:0] commit_ptr_o,
  output logic [ROB_SEL:0]   free_cnt_o,
  output logic               full_o,
  output logic               empty_o,
  output logic               error_o
);

  localparam logic [ROB_SEL:0] ROB_NUM_W = (ROB_SEL+1)'(ROB_NUM);

  logic [ROB_SEL-1:0] dispatch_ptr_q, dispatch_ptr_d;
  logic [ROB_SEL-1:0] commit_ptr_q, commit_ptr_d;
  logic [ROB_SEL:0]   used_q, used_d;
  logic               error_q, error_d;

  logic               req_legal;
  logic [ROB_SEL:0]   free_cnt;
  logic [ROB_SEL:0]   granted;
  logic [1:0]         commit_clip;
  logic               commit_over;
  logic [1:0]         commit_eff;

  assign free_cnt  = ROB_NUM_W - used_q;
  assign req_legal = (req_num_i == 2'd1) || (req_num_i == 2'd2);

  // Grant is gated by reset so nothing is offered while the block is held in reset.
  assign alloc_ok_o = reset & !stall_i & !flush_i & req_legal &
                      (free_cnt >= (ROB_SEL+1)'(req_num_i));
  assign dp1_o      = alloc_ok_o;
  assign dp2_o      = alloc_ok_o & (req_num_i == 2'd2);
  assign dp1_addr_o = dispatch_ptr_q;
  assign dp2_addr_o = dispatch_ptr_q + ROB_SEL'(1);
  assign granted    = (ROB_SEL+1)'(dp1_o) + (ROB_SEL+1)'(dp2_o);

  // A retire count of 3 is treated as 2, then limited to what is actually occupied.
  assign commit_clip = (commit_num_i == 2'd3) ? 2'd2 : commit_num_i;
  assign commit_over = (ROB_SEL+1)'(commit_clip) > used_q;
  assign commit_eff  = commit_over ? used_q[1:0] : commit_clip;

  always_comb begin
    commit_ptr_d = commit_ptr_q + ROB_SEL'(commit_eff);
    error_d      = error_q | commit_over | (commit_num_i == 2'd3) | (req_num_i == 2'd3);
    if (flush_i) begin
      dispatch_ptr_d = commit_ptr_q + ROB_SEL'(commit_eff);
      used_d         = '0;
    end else begin
      dispatch_ptr_d = dispatch_ptr_q + granted[ROB_SEL-1:0];
      used_d         = used_q + granted - (ROB_SEL+1)'(commit_eff);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dispatch_ptr_q <= '0;
      commit_ptr_q   <= '0;
      used_q         <= '0;
      error_q        <= 1'b0;
    end else begin
      dispatch_ptr_q <= dispatch_ptr_d;
      commit_ptr_q   <= commit_ptr_d;
      used_q         <= used_d;
      error_q        <= error_d;
    end
  end

  assign dispatch_ptr_o = dispatch_ptr_q;
  assign commit_ptr_o   = commit_ptr_q;
  assign free_cnt_o     = free_cnt;
  // Occupancy, not pointer equality, tells full from empty.
  assign full_o         = (used_q == ROB_NUM_W);
  assign empty_o        = (used_q == '0);
  assign error_o        = error_q;

endmodule

// File: tb/tb_rob_alloc.sv
// Directed bench for rob_alloc with an 8-entry ROB; each task checks one scenario
// against hand-computed values.
module tb_rob_alloc;
  localparam int ROB_NUM = 8;
  localparam int ROB_SEL = 3;

  logic               clk;
  logic               reset;
  logic [1:0]         req_num_i;
  logic               stall_i;
  logic               flush_i;
  logic [1:0]         commit_num_i;
  logic               alloc_ok_o;
  logic               dp1_o;
  logic [ROB_SEL-1:0] dp1_addr_o;
  logic               dp2_o;
  logic [ROB_SEL-1:0] dp2_addr_o;
  logic [ROB_SEL-1:0] dispatch_ptr_o;
  logic [ROB_SEL-1:0] commit_ptr_o;
  logic [ROB_SEL:0]   free_cnt_o;
  logic               full_o;
  logic               empty_o;
  logic               error_o;

  int n_chk;
  int n_fail;

  rob_alloc #(.ROB_NUM(ROB_NUM), .ROB_SEL(ROB_SEL)) dut (
    .clk(clk), .reset(reset), .req_num_i(req_num_i), .stall_i(stall_i),
    .flush_i(flush_i), .commit_num_i(commit_num_i), .alloc_ok_o(alloc_ok_o),
    .dp1_o(dp1_o), .dp1_addr_o(dp1_addr_o), .dp2_o(dp2_o), .dp2_addr_o(dp2_addr_o),
    .dispatch_ptr_o(dispatch_ptr_o), .commit_ptr_o(commit_ptr_o),
    .free_cnt_o(free_cnt_o), .full_o(full_o), .empty_o(empty_o), .error_o(error_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one cycle; inputs are driven and outputs sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] req, input logic [1:0] cmt, input logic stl, input logic fl);
    req_num_i = req; commit_num_i = cmt; stall_i = stl; flush_i = fl;
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    drive(2'd0, 2'd0, 1'b0, 1'b0);
    step();
    step();
    reset = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    drive(2'd2, 2'd0, 1'b0, 1'b0);
    step();
    n_chk++; if (dispatch_ptr_o !== 3'd0) begin n_fail++; $display("FAIL rst_dptr got %0d want 0", dispatch_ptr_o); end
    n_chk++; if (commit_ptr_o !== 3'd0) begin n_fail++; $display("FAIL rst_cptr got %0d want 0", commit_ptr_o); end
    n_chk++; if (free_cnt_o !== 4'd8) begin n_fail++; $display("FAIL rst_free got %0d want 8", free_cnt_o); end
    n_chk++; if (full_o !== 1'b0) begin n_fail++; $display("FAIL rst_full got %0b want 0", full_o); end
    n_chk++; if (empty_o !== 1'b1) begin n_fail++; $display("FAIL rst_empty got %0b want 1", empty_o); end
    n_chk++; if (error_o !== 1'b0) begin n_fail++; $display("FAIL rst_error got %0b want 0", error_o); end
    n_chk++; if ({alloc_ok_o, dp1_o, dp2_o} !== 3'b000) begin n_fail++; $display("FAIL rst_grant got %b want 000", {alloc_ok_o, dp1_o, dp2_o}); end
    drive(2'd0, 2'd0, 1'b0, 1'b0);
    reset = 1'b1;
    #1;
    $display("test_reset done");
  endtask

  task automatic test_stall();
    drive(2'd2, 2'd0, 1'b1, 1'b0);
    n_chk++; if (alloc_ok_o !== 1'b0) begin n_fail++; $display("FAIL stall_ok got %0b want 0", alloc_ok_o); end
    step();
    n_chk++; if (dispatch_ptr_o !== 3'd0) begin n_fail++; $display("FAIL stall_dptr got %0d want 0", dispatch_ptr_o); end
    $display("test_stall done");
  endtask

  task automatic test_fill();
    for (int i = 0; i < 4; i++) begin
      drive(2'd2, 2'd0, 1'b0, 1'b0);
      n_chk++; if ({alloc_ok_o, dp1_o, dp2_o} !== 3'b111) begin n_fail++; $display("FAIL fill_grant%0d got %b want 111", i, {alloc_ok_o, dp1_o, dp2_o}); end
      n_chk++; if (dp1_addr_o !== 3'(2*i)) begin n_fail++; $display("FAIL fill_a1_%0d got %0d want %0d", i, dp1_addr_o, 2*i); end
      n_chk++; if (dp2_addr_o !== 3'(2*i+1)) begin n_fail++; $display("FAIL fill_a2_%0d got %0d want %0d", i, dp2_addr_o, 2*i+1); end
      $display("fill tx %0d addr (%0d,%0d)", i, dp1_addr_o, dp2_addr_o);
      step();
    end
    drive(2'd2, 2'd0, 1'b0, 1'b0);
    n_chk++; if (free_cnt_o !== 4'd0) begin n_fail++; $display("FAIL fill_free got %0d want 0", free_cnt_o); end
    n_chk++; if (full_o !== 1'b1) begin n_fail++; $display("FAIL fill_full got %0b want 1", full_o); end
    n_chk++; if (alloc_ok_o !== 1'b0) begin n_fail++; $display("FAIL fill_5th got %0b want 0", alloc_ok_o); end
  endtask

  task automatic test_no_bypass();
    drive(2'd2, 2'd2, 1'b0, 1'b0);
    n_chk++; if (alloc_ok_o !== 1'b0) begin n_fail++; $display("FAIL nbp_same got %0b want 0", alloc_ok_o); end
    step();
    drive(2'd2, 2'd0, 1'b0, 1'b0);
    n_chk++; if (alloc_ok_o !== 1'b1) begin n_fail++; $display("FAIL nbp_next got %0b want 1", alloc_ok_o); end
    n_chk++; if ({dp1_addr_o, dp2_addr_o} !== {3'd0, 3'd1}) begin n_fail++; $display("FAIL nbp_addr got (%0d,%0d) want (0,1)", dp1_addr_o, dp2_addr_o); end
    step();
    drive(2'd0, 2'd0, 1'b0, 1'b0);
    n_chk++; if (commit_ptr_o !== 3'd2) begin n_fail++; $display("FAIL nbp_cptr got %0d want 2", commit_ptr_o); end
    n_chk++; if (free_cnt_o !== 4'd0) begin n_fail++; $display("FAIL nbp_free got %0d want 0", free_cnt_o); end
    $display("test_no_bypass done");
  endtask

  task automatic test_all_or_nothing();
    drive(2'd0, 2'd1, 1'b0, 1'b0);
    step();
    drive(2'd2, 2'd0, 1'b0, 1'b0);
    n_chk++; if (free_cnt_o !== 4'd1) begin n_fail++; $display("FAIL aon_free got %0d want 1", free_cnt_o); end
    n_chk++; if ({alloc_ok_o, dp1_o} !== 2'b00) begin n_fail++; $display("FAIL aon_refuse got %b want 00", {alloc_ok_o, dp1_o}); end
    step();
    n_chk++; if (dispatch_ptr_o !== 3'd2) begin n_fail++; $display("FAIL aon_dptr got %0d want 2", dispatch_ptr_o); end
    drive(2'd1, 2'd0, 1'b0, 1'b0);
    n_chk++; if ({alloc_ok_o, dp1_o, dp2_o} !== 3'b110) begin n_fail++; $display("FAIL aon_one got %b want 110", {alloc_ok_o, dp1_o, dp2_o}); end
    n_chk++; if (dp1_addr_o !== 3'd2) begin n_fail++; $display("FAIL aon_addr got %0d want 2", dp1_addr_o); end
    step();
    n_chk++; if (full_o !== 1'b1) begin n_fail++; $display("FAIL aon_full got %0b want 1", full_o); end
    n_chk++; if (dispatch_ptr_o !== 3'd3) begin n_fail++; $display("FAIL aon_dptr2 got %0d want 3", dispatch_ptr_o); end
    $display("test_all_or_nothing done");
  endtask

  // From used=8, cp=3, dp=3: free space while grants march the tail to 7.
  task automatic test_wrap();
    drive(2'd0, 2'd2, 1'b0, 1'b0);
    step();
    drive(2'd2, 2'd2, 1'b0, 1'b0);
    step();
    drive(2'd2, 2'd2, 1'b0, 1'b0);
    step();
    drive(2'd2, 2'd0, 1'b0, 1'b0);
    n_chk++; if (dispatch_ptr_o !== 3'd7) begin n_fail++; $display("FAIL wrap_dptr got %0d want 7", dispatch_ptr_o); end
    n_chk++; if (alloc_ok_o !== 1'b1) begin n_fail++; $display("FAIL wrap_ok got %0b want 1", alloc_ok_o); end
    n_chk++; if ({dp1_addr_o, dp2_addr_o} !== {3'd7, 3'd0}) begin n_fail++; $display("FAIL wrap_addr got (%0d,%0d) want (7,0)", dp1_addr_o, dp2_addr_o); end
    step();
    n_chk++; if (dispatch_ptr_o !== 3'd1) begin n_fail++; $display("FAIL wrap_next got %0d want 1", dispatch_ptr_o); end
    $display("test_wrap done");
  endtask

  task automatic test_flush();
    do_reset();
    drive(2'd2, 2'd0, 1'b0, 1'b0);
    step();
    drive(2'd2, 2'd2, 1'b0, 1'b0);
    step();
    drive(2'd2, 2'd1, 1'b0, 1'b0);
    step();
    drive(2'd2, 2'd0, 1'b0, 1'b0);
    step();
    drive(2'd2, 2'd1, 1'b0, 1'b1);
    n_chk++; if (free_cnt_o !== 4'd3) begin n_fail++; $display("FAIL fl_pre_free got %0d want 3", free_cnt_o); end
    n_chk++; if (commit_ptr_o !== 3'd3) begin n_fail++; $display("FAIL fl_pre_cptr got %0d want 3", commit_ptr_o); end
    n_chk++; if ({alloc_ok_o, dp1_o, dp2_o} !== 3'b000) begin n_fail++; $display("FAIL fl_grant got %b want 000", {alloc_ok_o, dp1_o, dp2_o}); end
    step();
    drive(2'd0, 2'd0, 1'b0, 1'b0);
    n_chk++; if (commit_ptr_o !== 3'd4) begin n_fail++; $display("FAIL fl_cptr got %0d want 4", commit_ptr_o); end
    n_chk++; if (dispatch_ptr_o !== 3'd4) begin n_fail++; $display("FAIL fl_dptr got %0d want 4", dispatch_ptr_o); end
    n_chk++; if (empty_o !== 1'b1) begin n_fail++; $display("FAIL fl_empty got %0b want 1", empty_o); end
    $display("test_flush done");
  endtask

  task automatic test_errors();
    drive(2'd1, 2'd0, 1'b0, 1'b0);
    step();
    drive(2'd0, 2'd2, 1'b0, 1'b0);
    n_chk++; if (error_o !== 1'b0) begin n_fail++; $display("FAIL err_pre got %0b want 0", error_o); end
    step();
    drive(2'd0, 2'd0, 1'b0, 1'b0);
    n_chk++; if (free_cnt_o !== 4'd8) begin n_fail++; $display("FAIL err_free got %0d want 8", free_cnt_o); end
    n_chk++; if (commit_ptr_o !== 3'd5) begin n_fail++; $display("FAIL err_cptr got %0d want 5", commit_ptr_o); end
    n_chk++; if (error_o !== 1'b1) begin n_fail++; $display("FAIL err_set got %0b want 1", error_o); end
    step();
    step();
    n_chk++; if (error_o !== 1'b1) begin n_fail++; $display("FAIL err_sticky got %0b want 1", error_o); end
    drive(2'd3, 2'd0, 1'b0, 1'b0);
    n_chk++; if ({alloc_ok_o, dp1_o, dp2_o} !== 3'b000) begin n_fail++; $display("FAIL err_req3 got %b want 000", {alloc_ok_o, dp1_o, dp2_o}); end
    step();
    drive(2'd1, 2'd0, 1'b0, 1'b0);
    n_chk++; if (dispatch_ptr_o !== 3'd5) begin n_fail++; $display("FAIL err_req3_dptr got %0d want 5", dispatch_ptr_o); end
    step();
    n_chk++; if (free_cnt_o !== 4'd7) begin n_fail++; $display("FAIL err_pre_rst got %0d want 7", free_cnt_o); end
    #2;
    reset = 1'b0;
    #1;
    n_chk++; if (error_o !== 1'b0) begin n_fail++; $display("FAIL err_rst_err got %0b want 0", error_o); end
    n_chk++; if (free_cnt_o !== 4'd8) begin n_fail++; $display("FAIL err_rst_free got %0d want 8", free_cnt_o); end
    n_chk++; if (dispatch_ptr_o !== 3'd0) begin n_fail++; $display("FAIL err_rst_dptr got %0d want 0", dispatch_ptr_o); end
    $display("test_errors done");
  endtask

  initial begin
    n_chk = 0;
    n_fail = 0;
    reset = 1'b0;
    req_num_i = 2'd0; commit_num_i = 2'd0; stall_i = 1'b0; flush_i = 1'b0;
    test_reset();
    test_stall();
    test_fill();
    test_no_bypass();
    test_all_or_nothing();
    test_wrap();
    test_flush();
    test_errors();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
